// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the team's APB master and the register-file
// completer. Signal names keep the completer's i_/o_ view so the slave
// modport reads naturally inside apb_slave_regfile.
interface apb_slave_regfile_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);

   logic [ADDR_WIDTH-1:0] i_paddr;
   logic                  i_psel;
   logic                  i_penable;
   logic                  i_pwrite;
   logic [DATA_WIDTH-1:0] i_pwdata;
   logic                  o_pready;
   logic                  o_pslverr;
   logic [DATA_WIDTH-1:0] o_prdata;

   // Requester side: drives the request, observes the response.
   modport master (
      output i_paddr,
      output i_psel,
      output i_penable,
      output i_pwrite,
      output i_pwdata,
      input  o_pready,
      input  o_pslverr,
      input  o_prdata
   );

   // Completer side: observes the request, drives the response.
   modport slave (
      input  i_paddr,
      input  i_psel,
      input  i_penable,
      input  i_pwrite,
      input  i_pwdata,
      output o_pready,
      output o_pslverr,
      output o_prdata
   );

endinterface : apb_slave_regfile_if

// File: rtl/apb_slave_regfile.sv
// APB completer backed by a bank of NUM_REGS read/write registers.
// Every transfer is stretched by WAIT_STATES access cycles with o_pready low;
// misaligned or out-of-range addresses complete with o_pslverr set and never
// touch the bank. All register contents are also exposed flat on o_regs.
module apb_slave_regfile #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_REGS    = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic                           i_clk,
   input  logic                           i_reset_n,
   apb_slave_regfile_if.slave             apb,
   output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs
);

   // Word index taken from the byte address; the low two bits only matter
   // for the alignment check.
   localparam int IDX_W = ADDR_WIDTH - 2;

   // Elaboration-time guards on the parameter ranges the logic relies on.
   if (ADDR_WIDTH < 3) begin : g_chk_aw
      $error("apb_slave_regfile: ADDR_WIDTH must be at least 3");
   end
   if ((NUM_REGS < 1) || (NUM_REGS > (1 << IDX_W))) begin : g_chk_nr
      $error("apb_slave_regfile: NUM_REGS out of range for ADDR_WIDTH");
   end
   if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_chk_ws
      $error("apb_slave_regfile: WAIT_STATES must be within 0..15");
   end

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   // Transfer context latched in the setup phase.
   state_t              state_q;
   logic [3:0]          cnt_q;
   logic [IDX_W-1:0]    idx_q;
   logic                wr_q;
   logic                err_q;

   // Register bank.
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

   // Decode of the live address, used only when a setup phase is seen.
   logic [IDX_W-1:0]    idx_in;
   logic                err_in;
   logic                setup;
   logic                complete;
   logic                wr_commit;
   logic [DATA_WIDTH-1:0] rd_word;

   assign idx_in = apb.i_paddr[ADDR_WIDTH-1:2];
   // Compare at 32 bits so NUM_REGS == 2**IDX_W does not wrap to zero.
   assign err_in = (apb.i_paddr[1:0] != 2'b00) ||
                   (32'(idx_in) >= 32'(NUM_REGS));

   assign setup = apb.i_psel & ~apb.i_penable;

   // The completion cycle: waits exhausted and the master still holding
   // the access phase. Dropping i_psel here aborts instead of completing.
   assign complete  = (state_q == ACCESS) && (cnt_q == 4'd0) &&
                      apb.i_psel && apb.i_penable;
   assign wr_commit = complete && wr_q && !err_q;

   // Transfer sequencer: setup latch, wait countdown, abort and completion.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // An access phase without a preceding setup is ignored here.
               if (setup) begin
                  idx_q   <= idx_in;
                  wr_q    <= apb.i_pwrite;
                  err_q   <= err_in;
                  cnt_q   <= 4'(WAIT_STATES);
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               if (!apb.i_psel) begin
                  state_q <= IDLE;
               end else if (apb.i_penable) begin
                  if (cnt_q != 4'd0) begin
                     cnt_q <= cnt_q - 4'd1;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Register bank write port: commits only on an error-free write completion.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            regs_q[k] <= '0;
         end
      end else if (wr_commit) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (idx_q == IDX_W'(k)) begin
               regs_q[k] <= apb.i_pwdata;
            end
         end
      end
   end

   // Read mux over the bank; an index past the bank yields zero.
   always_comb begin
      rd_word = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            rd_word = regs_q[k];
         end
      end
   end

   // Response outputs: all quiet except in the completion cycle.
   always_comb begin
      apb.o_pready  = complete;
      apb.o_pslverr = complete && err_q;
      apb.o_prdata  = (complete && !wr_q && !err_q) ? rd_word : '0;
   end

   // Flat view of the bank for downstream control logic.
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_flat
      assign o_regs[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
   end

endmodule : apb_slave_regfile

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: three instances (WAIT_STATES 1, 0
// and 15) share one clock, reset and request bus; i_psel is steered to the
// instance under test. Expected responses come from a per-instance register
// model and are queued when a transfer is issued, then popped on o_pready.
module tb_apb_slave_regfile;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int NR = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Shared request drive and target selector.
   logic [AW-1:0] paddr;
   logic          psel;
   logic          penable;
   logic          pwrite;
   logic [DW-1:0] pwdata;
   int            tgt;

   apb_slave_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_a ();
   apb_slave_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_b ();
   apb_slave_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_c ();

   logic [NR*DW-1:0] regs_a, regs_b, regs_c;

   assign if_a.i_paddr = paddr;   assign if_b.i_paddr = paddr;   assign if_c.i_paddr = paddr;
   assign if_a.i_penable = penable; assign if_b.i_penable = penable; assign if_c.i_penable = penable;
   assign if_a.i_pwrite = pwrite; assign if_b.i_pwrite = pwrite; assign if_c.i_pwrite = pwrite;
   assign if_a.i_pwdata = pwdata; assign if_b.i_pwdata = pwdata; assign if_c.i_pwdata = pwdata;
   assign if_a.i_psel = psel && (tgt == 0);
   assign if_b.i_psel = psel && (tgt == 1);
   assign if_c.i_psel = psel && (tgt == 2);

   apb_slave_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(1)) u_ws1 (
      .i_clk(clk), .i_reset_n(rst_n), .apb(if_a), .o_regs(regs_a));
   apb_slave_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(0)) u_ws0 (
      .i_clk(clk), .i_reset_n(rst_n), .apb(if_b), .o_regs(regs_b));
   apb_slave_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(15)) u_ws15 (
      .i_clk(clk), .i_reset_n(rst_n), .apb(if_c), .o_regs(regs_c));

   // Response of the instance under test.
   logic          m_pready;
   logic          m_pslverr;
   logic [DW-1:0] m_prdata;
   always_comb begin
      m_pready  = if_a.o_pready;
      m_pslverr = if_a.o_pslverr;
      m_prdata  = if_a.o_prdata;
      case (tgt)
         1: begin m_pready = if_b.o_pready; m_pslverr = if_b.o_pslverr; m_prdata = if_b.o_prdata; end
         2: begin m_pready = if_c.o_pready; m_pslverr = if_c.o_pslverr; m_prdata = if_c.o_prdata; end
         default: ;
      endcase
   end

   typedef struct {
      logic          err;
      logic [DW-1:0] rdata;
      int            lat;
   } exp_t;

   exp_t          sbq[$];
   logic [DW-1:0] mdl [3][NR];
   int            nvec = 0;
   int            nmis = 0;

   function automatic int ws_of(input int t);
      return (t == 0) ? 1 : ((t == 1) ? 0 : 15);
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_regs(input int t, input string tag);
      logic [255:0] e;
      logic [255:0] o;
      e = '0;
      for (int k = 0; k < NR; k++) e[k*DW +: DW] = mdl[t][k];
      o = (t == 0) ? regs_a : ((t == 1) ? regs_b : regs_c);
      chk(tag, o, e);
   endtask

   task automatic clear_model();
      for (int t = 0; t < 3; t++)
         for (int k = 0; k < NR; k++) mdl[t][k] = '0;
   endtask

   // One full transfer; returns at the negedge of the completion cycle with
   // the access phase still driven, so a following call is back-to-back.
   // Address and direction are deliberately disturbed during the access
   // phase: the completer must use what it latched at setup.
   task automatic xfer(input int t, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input string tag);
      exp_t e;
      int   idx;
      int   n;
      bit   done;
      idx     = int'(a[AW-1:2]);
      e.err   = (a[1:0] != 2'b00) || (idx >= NR);
      e.rdata = (!wr && !e.err) ? mdl[t][idx] : '0;
      e.lat   = ws_of(t) + 1;
      sbq.push_back(e);
      if (wr && !e.err) mdl[t][idx] = d;
      @(posedge clk); #1;
      tgt = t; psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = d;
      @(posedge clk); #1;
      penable = 1'b1; paddr = a ^ 8'h04; pwrite = ~wr;
      n = 0; done = 1'b0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
         if (m_pready) begin
            e = sbq.pop_front();
            chk({tag, "_lat"}, 256'(n), 256'(e.lat));
            chk({tag, "_pslverr"}, 256'(m_pslverr), 256'(e.err));
            if (!wr) chk({tag, "_prdata"}, 256'(m_prdata), 256'(e.rdata));
            done = 1'b1;
         end else begin
            chk({tag, "_quiet"}, {m_pslverr, m_prdata}, '0);
         end
      end
      if (!done) begin
         chk({tag, "_timeout_pready"}, 256'(m_pready), 256'(1));
         void'(sbq.pop_front());
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed hang expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; tgt = 0;
      clear_model();
      repeat (3) @(posedge clk);
      @(negedge clk);
      // Reset state of all instances.
      chk("rst_pready", if_a.o_pready, 0);
      chk("rst_pslverr", if_a.o_pslverr, 0);
      chk("rst_prdata", if_a.o_prdata, 0);
      chk("rst_regs_ws1", regs_a, 0);
      chk("rst_regs_ws0", regs_b, 0);
      chk("rst_regs_ws15", regs_c, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Write then back-to-back read, then read the untouched registers.
      xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, "wr04");
      xfer(0, 1'b0, 8'h04, 32'h0, "rd04");
      for (int k = 0; k < NR; k++) begin
         if (k != 1) xfer(0, 1'b0, 8'(k * 4), 32'h0, "rd_other");
      end
      idle();
      chk_regs(0, "regs_after_wr04");

      // Out-of-range and unaligned accesses.
      xfer(0, 1'b1, 8'h20, 32'h12345678, "wr20_err");
      xfer(0, 1'b1, 8'h05, 32'h12345678, "wr05_err");
      idle();
      chk_regs(0, "regs_after_err");
      xfer(0, 1'b0, 8'h20, 32'h0, "rd20_err");
      idle();

      // Abort: select dropped in the wait cycle of a write to 0x08.
      @(posedge clk); #1;
      tgt = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'hA5A5A5A5;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b1;
      @(negedge clk);
      chk("abort_pready_wait", m_pready, 0);
      @(posedge clk); #1 penable = 1'b0;
      @(negedge clk);
      chk("abort_pready_after", m_pready, 0);
      chk_regs(0, "abort_regs");
      xfer(0, 1'b1, 8'h08, 32'h0BADF00D, "wr08_after_abort");
      idle();
      chk_regs(0, "regs_after_wr08");

      // Access phase without setup is ignored.
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h77777777;
      repeat (3) begin
         @(negedge clk);
         chk("viol_pready", m_pready, 0);
      end
      idle();
      chk_regs(0, "viol_regs");

      // Reset in the wait cycle of a write to 0x0C; bus left in access phase.
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h13579BDF;
      @(posedge clk); #1;
      penable = 1'b1; rst_n = 1'b0;
      @(negedge clk);
      chk("rstmid_pready_wait", m_pready, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      clear_model();
      @(negedge clk);
      chk("rstmid_pready_after", m_pready, 0);
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      chk_regs(0, "rstmid_regs");
      xfer(0, 1'b0, 8'h04, 32'h0, "rd04_after_rst");
      xfer(0, 1'b1, 8'h0C, 32'h5555AAAA, "wr0C_after_rst");
      idle();
      chk_regs(0, "regs_after_rst_wr");

      // Wait-state extremes: 2 and 17 cycles per transfer including setup.
      xfer(1, 1'b1, 8'h1C, 32'hCAFEF00D, "ws0_wr");
      xfer(1, 1'b0, 8'h1C, 32'h0, "ws0_rd");
      idle();
      chk_regs(1, "ws0_regs");
      xfer(2, 1'b1, 8'h00, 32'hFEEDC0DE, "ws15_wr");
      xfer(2, 1'b0, 8'h00, 32'h0, "ws15_rd");
      idle();
      chk_regs(2, "ws15_regs");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule : tb_apb_slave_regfile
